multi_edge_detector: RTL and testbench
======================================

MULTI_EDGE_DETECTOR -- requirements
Module: multi_edge_detector

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning number of independent input channels (1..32).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning synchroniser flops per channel (2..4).
REQ-003 The block SHALL have parameter FILTER_CYCLES, default 4, meaning consecutive stable cycles required before a level change is accepted (1..255).
REQ-004 Port clk  input  1  sole clock; all state SHALL change on its rising edge only.
REQ-005 Port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port data_in  input  WIDTH  asynchronous raw levels, one bit per channel.
REQ-007 Port rise_en  input  WIDTH  per-channel enable for latching rising edges into edge_pending.
REQ-008 Port fall_en  input  WIDTH  per-channel enable for latching falling edges into edge_pending.
REQ-009 Port clear  input  WIDTH  per-channel write-1-to-clear for edge_pending, sampled each cycle.
REQ-010 Port rising_edge  output  WIDTH  one-cycle pulse per accepted 0->1 filtered transition.
REQ-011 Port falling_edge  output  WIDTH  one-cycle pulse per accepted 1->0 filtered transition.
REQ-012 Port level  output  WIDTH  current filtered level per channel.
REQ-013 Port edge_pending  output  WIDTH  sticky per-channel edge flag.
REQ-014 Port irq  output  1  OR-reduction of edge_pending.

Function
REQ-015 Each channel SHALL pass data_in through a SYNC_STAGES-deep flop chain; the chain output is the channel's sync value s.
REQ-016 Each channel SHALL hold a stability counter: when s equals level, the counter SHALL reset to 0; when s differs from level, the counter SHALL increment by 1.
REQ-017 When s differs from level and the counter equals FILTER_CYCLES-1, level SHALL toggle and the counter SHALL reset to 0 on that same edge.
REQ-018 A glitch on s shorter than FILTER_CYCLES cycles SHALL produce no level change and no pulse, because the counter restarts at 0.
REQ-019 rising_edge/falling_edge SHALL be registered and asserted on the same edge that level toggles, for exactly one cycle, regardless of rise_en/fall_en.
REQ-020 Latency: a data_in change stable before clock edge 1 SHALL produce its pulse and level change visible after edge SYNC_STAGES+FILTER_CYCLES.
REQ-021 FILTER_CYCLES=1 SHALL accept a change on the first cycle s differs (no filtering).
REQ-022 edge_pending[i] SHALL set on the edge where (rising_edge pulse AND rise_en[i]) or (falling_edge pulse AND fall_en[i]) is being registered.
REQ-023 edge_pending[i] SHALL clear when clear[i]=1; when set and clear coincide, set SHALL win.
REQ-024 irq SHALL be a combinational OR of the edge_pending registers only (glitch-free).
REQ-025 Channels SHALL be fully independent; simultaneous edges on any subset of channels SHALL all be reported in the same cycle.
REQ-026 The counter width SHALL be ceil(log2(FILTER_CYCLES+1)) and SHALL never wrap.

Reset
REQ-027 While reset_n=0, all sync flops, counters, level, rising_edge, falling_edge, edge_pending SHALL be 0 and irq SHALL be 0.
REQ-028 Reset asserted mid-filter SHALL discard any partial count; after release, a channel held high SHALL report one rising edge after the REQ-020 latency.

Structure
REQ-029 Parameter defaults, legal ranges and the counter-width function SHALL live in shared package edge_det_pkg.
REQ-030 One sub-module, edge_chan (sync chain, filter, pulse, sticky flag for one bit), SHALL be instantiated WIDTH times by a generate loop.

Verification
REQ-031 Reset release with data_in=0xFF, defaults -> rising_edge=0xFF for one cycle after edge 6, level=0xFF.
REQ-032 Channel 0 high for 3 cycles then low, FILTER_CYCLES=4 -> no pulse, level[0] stays 0.
REQ-033 Channel 2 0->1, held 10 cycles, rise_en[2]=1 -> rising_edge[2] one cycle at edge 6, edge_pending[2]=1, irq=1; clear[2]=1 one cycle -> edge_pending[2]=0, irq=0.
REQ-034 Channel 5 1->0 with fall_en[5]=0 -> falling_edge[5] pulses, edge_pending[5] stays 0.
REQ-035 clear[1]=1 held on the pulse cycle of a channel-1 rising edge with rise_en[1]=1 -> edge_pending[1]=1 (set wins).
REQ-036 reset_n low for 1 cycle during channel 3 count at 2 -> all outputs 0 immediately; filter restarts from 0 after release.

Source files
------------

// File: rtl/edge_det_pkg.sv
// Shared parameter defaults, legal ranges and the stability-counter width
// helper for the multi-channel edge detector.
package edge_det_pkg;

    localparam int WIDTH_DEFAULT         = 8;
    localparam int WIDTH_MIN             = 1;
    localparam int WIDTH_MAX             = 32;

    localparam int SYNC_STAGES_DEFAULT   = 2;
    localparam int SYNC_STAGES_MIN       = 2;
    localparam int SYNC_STAGES_MAX       = 4;

    localparam int FILTER_CYCLES_DEFAULT = 4;
    localparam int FILTER_CYCLES_MIN     = 1;
    localparam int FILTER_CYCLES_MAX     = 255;

    // Wide enough to hold FILTER_CYCLES; the counter tops out at FILTER_CYCLES-1.
    function automatic int cnt_width(input int filter_cycles);
        return $clog2(filter_cycles + 1);
    endfunction

endpackage

// File: rtl/edge_chan.sv
// One channel: synchroniser chain, stability filter, registered edge pulses
// and a sticky, write-1-to-clear pending flag.
module edge_chan
    import edge_det_pkg::*;
#(
    parameter int SYNC_STAGES   = SYNC_STAGES_DEFAULT,
    parameter int FILTER_CYCLES = FILTER_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic data_in,
    input  logic rise_en,
    input  logic fall_en,
    input  logic clear,
    output logic rising_edge,
    output logic falling_edge,
    output logic level,
    output logic edge_pending
);

    localparam int CNT_W = cnt_width(FILTER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CNT_W-1:0]       cnt;
    logic                   accept;
    logic                   rise_d;
    logic                   fall_d;
    logic                   set_pending;

    assign s = sync_q[SYNC_STAGES-1];

    // A change is accepted once s has disagreed with level for FILTER_CYCLES edges in a row.
    assign accept      = (s != level) && (cnt == CNT_LAST);
    assign rise_d      = accept & ~level;
    assign fall_d      = accept & level;
    assign set_pending = (rise_d & rise_en) | (fall_d & fall_en);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q       <= '0;
            cnt          <= '0;
            level        <= 1'b0;
            rising_edge  <= 1'b0;
            falling_edge <= 1'b0;
            edge_pending <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], data_in};
            level        <= level ^ accept;
            rising_edge  <= rise_d;
            falling_edge <= fall_d;

            if (s == level || accept) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            // Set takes priority over a coincident clear.
            if (set_pending) begin
                edge_pending <= 1'b1;
            end else if (clear) begin
                edge_pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multi_edge_detector.sv
// WIDTH independent filtered edge detectors with a combined interrupt built
// only from the registered pending flags.
module multi_edge_detector
    import edge_det_pkg::*;
#(
    parameter int WIDTH         = WIDTH_DEFAULT,
    parameter int SYNC_STAGES   = SYNC_STAGES_DEFAULT,
    parameter int FILTER_CYCLES = FILTER_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] clear,
    output logic [WIDTH-1:0] rising_edge,
    output logic [WIDTH-1:0] falling_edge,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] edge_pending,
    output logic             irq
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        edge_chan #(
            .SYNC_STAGES   (SYNC_STAGES),
            .FILTER_CYCLES (FILTER_CYCLES)
        ) u_chan (
            .clk          (clk),
            .reset_n      (reset_n),
            .data_in      (data_in[i]),
            .rise_en      (rise_en[i]),
            .fall_en      (fall_en[i]),
            .clear        (clear[i]),
            .rising_edge  (rising_edge[i]),
            .falling_edge (falling_edge[i]),
            .level        (level[i]),
            .edge_pending (edge_pending[i])
        );
    end

    assign irq = |edge_pending;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Bench for multi_edge_detector: directed scenarios plus random traffic, with
// two instances (filter length 4 and 1) checked against a window-based model.
module tb_multi_edge_detector;

    localparam int W  = 8;
    localparam int SS = 2;
    localparam int F0 = 4;
    localparam int F1 = 1;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] data_in;
    logic [W-1:0] rise_en;
    logic [W-1:0] fall_en;
    logic [W-1:0] clear;

    logic [W-1:0] rise0, fall0, lvl0, pend0;
    logic         irq0;
    logic [W-1:0] rise1, fall1, lvl1, pend1;
    logic         irq1;

    int n_checks = 0;
    int n_errors = 0;

    multi_edge_detector #(.WIDTH(W), .SYNC_STAGES(SS), .FILTER_CYCLES(F0)) dut0 (
        .clk          (clk),
        .reset_n      (reset_n),
        .data_in      (data_in),
        .rise_en      (rise_en),
        .fall_en      (fall_en),
        .clear        (clear),
        .rising_edge  (rise0),
        .falling_edge (fall0),
        .level        (lvl0),
        .edge_pending (pend0),
        .irq          (irq0)
    );

    multi_edge_detector #(.WIDTH(W), .SYNC_STAGES(SS), .FILTER_CYCLES(F1)) dut1 (
        .clk          (clk),
        .reset_n      (reset_n),
        .data_in      (data_in),
        .rise_en      (rise_en),
        .fall_en      (fall_en),
        .clear        (clear),
        .rising_edge  (rise1),
        .falling_edge (fall1),
        .level        (lvl1),
        .edge_pending (pend1),
        .irq          (irq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: delayed samples of data_in, and per channel the
    // samples seen since the last accepted change.
    logic [W-1:0] pipe_m[2][$];
    bit           hist_m[2][W][$];
    logic [W-1:0] lvl_m[2];
    logic [W-1:0] rise_m[2];
    logic [W-1:0] fall_m[2];
    logic [W-1:0] pend_m[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            pipe_m[n] = {};
            for (int k = 0; k < SS; k++) pipe_m[n].push_back('0);
            for (int i = 0; i < W; i++) hist_m[n][i] = {};
            lvl_m[n]  = '0;
            rise_m[n] = '0;
            fall_m[n] = '0;
            pend_m[n] = '0;
        end
    endtask

    task automatic model_edge(input int n, input int f);
        logic [W-1:0] s;
        bit           all_differ;
        s = pipe_m[n].pop_front();
        pipe_m[n].push_back(data_in);
        rise_m[n] = '0;
        fall_m[n] = '0;
        for (int i = 0; i < W; i++) begin
            hist_m[n][i].push_back(s[i]);
            if (hist_m[n][i].size() > f) void'(hist_m[n][i].pop_front());
            all_differ = (hist_m[n][i].size() == f);
            foreach (hist_m[n][i][k]) begin
                if (hist_m[n][i][k] == lvl_m[n][i]) all_differ = 0;
            end
            if (all_differ) begin
                if (lvl_m[n][i]) fall_m[n][i] = 1'b1;
                else             rise_m[n][i] = 1'b1;
                lvl_m[n][i] = ~lvl_m[n][i];
                hist_m[n][i] = {};
            end
            if ((rise_m[n][i] && rise_en[i]) || (fall_m[n][i] && fall_en[i])) pend_m[n][i] = 1'b1;
            else if (clear[i]) pend_m[n][i] = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("rise0", rise0, rise_m[0]);
        check("fall0", fall0, fall_m[0]);
        check("level0", lvl0, lvl_m[0]);
        check("pend0", pend0, pend_m[0]);
        check("irq0", irq0, |pend_m[0]);
        check("rise1", rise1, rise_m[1]);
        check("fall1", fall1, fall_m[1]);
        check("level1", lvl1, lvl_m[1]);
        check("pend1", pend1, pend_m[1]);
        check("irq1", irq1, |pend_m[1]);
    endtask

    // One clock edge: advance the model with the inputs the DUT samples, then compare.
    task automatic step();
        @(posedge clk);
        if (!reset_n) begin
            model_reset();
        end else begin
            model_edge(0, F0);
            model_edge(1, F1);
        end
        #1;
        compare_all();
    endtask

    task automatic steps(input int k);
        for (int j = 0; j < k; j++) step();
    endtask

    logic seen_rise0;

    initial begin
        reset_n = 1'b0;
        data_in = 8'hFF;
        rise_en = '0;
        fall_en = '0;
        clear   = '0;
        model_reset();

        // Reset release with all inputs high: all channels rise at edge 6.
        steps(3);
        check("reset_rise", rise0, 0);
        check("reset_level", lvl0, 0);
        check("reset_irq", irq0, 0);
        reset_n = 1'b1;
        steps(5);
        check("all_rise_early", rise0, 0);
        step();
        check("all_rise_edge6", rise0, 8'hFF);
        check("all_level_edge6", lvl0, 8'hFF);
        step();
        check("all_rise_one_cycle", rise0, 0);

        // Three-cycle glitch on channel 0 is filtered out.
        data_in = 8'h00;
        steps(8);
        data_in = 8'h01;
        seen_rise0 = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            seen_rise0 |= rise0[0];
        end
        data_in = 8'h00;
        for (int j = 0; j < 8; j++) begin
            step();
            seen_rise0 |= rise0[0];
        end
        check("glitch_no_pulse", seen_rise0, 0);
        check("glitch_level", lvl0[0], 0);

        // Channel 2 rising edge with enable, then write-1-to-clear.
        rise_en = 8'h04;
        data_in = 8'h04;
        steps(5);
        check("ch2_rise_early", rise0[2], 0);
        step();
        check("ch2_rise", rise0[2], 1);
        check("ch2_pend", pend0[2], 1);
        check("ch2_irq", irq0, 1);
        step();
        check("ch2_rise_drop", rise0[2], 0);
        steps(3);
        clear = 8'h04;
        step();
        clear = 8'h00;
        check("ch2_cleared", pend0[2], 0);
        check("ch2_irq_clr", irq0, 0);

        // Channel 5 falling edge with fall_en low: pulse but no pending.
        data_in = 8'h24;
        steps(8);
        fall_en = 8'h00;
        data_in = 8'h04;
        steps(6);
        check("ch5_fall", fall0[5], 1);
        check("ch5_no_pend", pend0[5], 0);
        step();

        // Channel 1: set and clear on the same edge, set wins.
        rise_en = 8'h02;
        clear   = 8'h02;
        data_in = 8'h06;
        steps(6);
        check("ch1_rise", rise0[1], 1);
        check("ch1_set_wins", pend0[1], 1);
        step();
        check("ch1_cleared_after", pend0[1], 0);
        clear   = 8'h00;
        rise_en = 8'h00;

        // Reset mid-filter on channel 3.
        data_in = 8'h00;
        steps(8);
        data_in = 8'h08;
        steps(4);
        reset_n = 1'b0;
        model_reset();
        #1;
        check("midrst_rise", rise1 | rise0, 0);
        check("midrst_level", lvl0 | lvl1, 0);
        check("midrst_pend", pend0 | pend1, 0);
        check("midrst_irq", irq0 | irq1, 0);
        step();
        reset_n = 1'b1;
        steps(5);
        check("midrst_restart_early", rise0[3], 0);
        step();
        check("midrst_restart_rise", rise0, 8'h08);
        check("midrst_restart_level", lvl0, 8'h08);

        // Random traffic against the model.
        for (int j = 0; j < 600; j++) begin
            if ($urandom_range(0, 4) == 0) data_in = data_in ^ W'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) rise_en = W'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) fall_en = W'($urandom_range(0, 255));
            clear = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 255)) : '0;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
